regfile_wb_sched: RTL and testbench
===================================

REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 2: entries per requester queue (power of 2, >=2).
REQ-002 SHALL have parameter NOREG, default 4'hF: idle destination code driven on an unused write port.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports e_valid in 1, e_ready out 1, e_dst in 4, e_data in 32: execute-stage write request.
REQ-006 SHALL have ports m_valid in 1, m_ready out 1, m_dst in 4, m_data in 32: memory-stage write request.
REQ-007 SHALL have ports dstE out 4, valE out 32, dstM out 4, valM out 32: register-file write ports (8 registers, r0..r7).
REQ-008 SHALL have port pending  out  8  bit r set while any write to register r is queued or presented on dstE/dstM.
REQ-009 SHALL have ports idle out 1 (both queues and both port registers empty) and bad_dst out 1 (sticky error flag).

Function
REQ-010 SHALL hold one FIFO of DEPTH entries {dst[2:0], data[31:0]} per requester; e_ready = E queue not full, m_ready = M queue not full.
REQ-011 SHALL accept a request on a posedge where valid && ready; a full queue keeps ready low even if it pops in the same cycle (no full-queue bypass).
REQ-012 SHALL discard any accepted request with dst > 7, leave its queue unchanged, and set bad_dst until reset.
REQ-013 SHALL register dstE/valE/dstM/valM; a request accepted at edge N into an empty queue with no conflict SHALL appear on its port after edge N+1 (one-cycle latency, one cycle valid).
REQ-014 SHALL drive NOREG and zero data on a port in every cycle it has nothing to issue.
REQ-015 SHALL issue per cycle at most one E head to dstE and one M head to dstM; each queue preserves FIFO order.
REQ-016 Conflict: both heads present with equal dst -> issue only the winner; the loser head is held and issued no earlier than the next cycle.
REQ-017 Winner: E by default (so the later M write lands last); a held M head sets flag m_prio, and while m_prio=1 M wins the next conflict; m_prio clears whenever M issues; M SHALL never be deferred twice in a row.
REQ-018 Heads with different dst SHALL both issue in the same cycle.
REQ-019 pending SHALL be combinational from queue contents and port registers, and SHALL include entries accepted at the current edge by the following cycle.
REQ-020 Simultaneous accept and issue on one queue SHALL keep its count unchanged.

Reset
REQ-021 While reset=1: queues empty, m_prio=0, dstE=dstM=NOREG, valE=valM=0, pending=0, bad_dst=0, idle=1, e_ready=m_ready=1.
REQ-022 Reset asserted mid-operation SHALL drop all queued and presented writes; no write port shows a non-NOREG value during reset or in the cycle after deassertion.

Structure
REQ-023 NOREG, NUM_REGS=8, the data width 32, and the write-request record type SHALL live in a shared package.
REQ-024 One sub-module wb_fifo (parameter DEPTH; push/pop/full/empty/head plus a per-entry dst-valid vector for pending) SHALL be instantiated twice.

Verification
REQ-025 E-only: e_dst=3, e_data=32'hABCDEF98 for one cycle -> next cycle dstE=3, valE=32'hABCDEF98, dstM=NOREG; pending[3]=1 from acceptance until the port clears.
REQ-026 Conflict: E and M both dst=5 (32'h1111_1111 / 32'h2222_2222) in one cycle -> cycle 1 dstE=5, dstM=NOREG; cycle 2 dstM=5, valM=32'h2222_2222.
REQ-027 Anti-starvation: E streams dst=2 every cycle while M issues dst=2 twice -> each M write deferred at most one cycle; E held on the cycle M wins.
REQ-028 Backpressure: DEPTH=2, M held in conflict, 3 M requests -> m_ready low after second accept; third accepted only after one pop; order preserved.
REQ-029 Bad destination: e_dst=4'h9 -> no write issued, bad_dst=1 sticky, queue count unchanged.
REQ-030 Reset mid-stream: queues holding 2 entries each, assert reset -> all outputs reach REQ-021 values immediately; no stale write after deassertion.

Source files
------------

// File: rtl/regfile_wb_sched_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
package regfile_wb_sched_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 3;

  // Destination code driven on a write port that has nothing to issue.
  localparam logic [3:0] NOREG = 4'hF;

  // One queued write: 3-bit register index plus data word.
  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Which requester wins the next same-destination conflict.
  typedef enum logic {
    PRIO_E = 1'b0,
    PRIO_M = 1'b1
  } wb_prio_e;

  // Requests arrive with a 4-bit destination; only r0..r7 exist.
  function automatic logic dst_in_range(input logic [3:0] d);
    dst_in_range = ~d[3];
  endfunction

  // One-hot register mask for a register index.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    reg_onehot    = '0;
    reg_onehot[r] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wb_sched_wb_fifo.sv
// Per-requester write queue: DEPTH entries, occupancy tracked per slot so the
// set of destinations still queued can be reported without a counter walk.
module wb_fifo
  import regfile_wb_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  wb_req_t             push_data_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output wb_req_t             head_o,
  output logic [NUM_REGS-1:0] dst_vld_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t          mem_q [DEPTH];
  logic [DEPTH-1:0] occ_q, occ_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = &occ_q;
  assign empty_o = ~|occ_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Next occupancy and pointers; push and pop never target the same slot.
  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_pop) begin
      occ_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + AW'(1);
    end
    if (do_push) begin
      occ_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
  end

  // Queue control state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are qualified by occupancy so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Destinations of all occupied entries.
  always_comb begin
    dst_vld_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (occ_q[i]) begin
        dst_vld_o = dst_vld_o | reg_onehot(mem_q[i].dst);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: queues execute- and memory-stage register writes and
// issues them onto two registered write ports, resolving same-register
// conflicts in E-then-M order with a one-deferral limit for M.
module regfile_wb_sched #(
  parameter int unsigned DEPTH = 2,
  parameter logic [3:0]  NOREG = regfile_wb_sched_pkg::NOREG
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        e_valid,
  output logic        e_ready,
  input  logic [3:0]  e_dst,
  input  logic [31:0] e_data,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [3:0]  m_dst,
  input  logic [31:0] m_data,
  output logic [3:0]  dstE,
  output logic [31:0] valE,
  output logic [3:0]  dstM,
  output logic [31:0] valM,
  output logic [7:0]  pending,
  output logic        idle,
  output logic        bad_dst
);

  import regfile_wb_sched_pkg::*;

  wb_req_t             e_req, m_req, e_head, m_head;
  logic                e_full, e_empty, m_full, m_empty;
  logic [NUM_REGS-1:0] e_dst_vld, m_dst_vld;
  logic                e_acc, m_acc, e_push, m_push;
  logic                conflict, issue_e, issue_m;

  wb_prio_e            prio_q, prio_d;
  logic [3:0]          dstE_q, dstE_d, dstM_q, dstM_d;
  logic [DATA_W-1:0]   valE_q, valE_d, valM_q, valM_d;
  logic                vldE_q, vldE_d, vldM_q, vldM_d;
  logic                bad_q, bad_d;

  assign e_ready = !e_full;
  assign m_ready = !m_full;
  assign e_acc   = e_valid && e_ready;
  assign m_acc   = m_valid && m_ready;
  assign e_push  = e_acc && dst_in_range(e_dst);
  assign m_push  = m_acc && dst_in_range(m_dst);
  assign e_req   = '{dst: e_dst[REG_AW-1:0], data: e_data};
  assign m_req   = '{dst: m_dst[REG_AW-1:0], data: m_data};

  wb_fifo #(.DEPTH(DEPTH)) u_e_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (e_push),
    .push_data_i (e_req),
    .pop_i       (issue_e),
    .full_o      (e_full),
    .empty_o     (e_empty),
    .head_o      (e_head),
    .dst_vld_o   (e_dst_vld)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_m_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (m_push),
    .push_data_i (m_req),
    .pop_i       (issue_m),
    .full_o      (m_full),
    .empty_o     (m_empty),
    .head_o      (m_head),
    .dst_vld_o   (m_dst_vld)
  );

  // Issue arbitration: on a same-register conflict only the priority holder
  // issues; an M head that loses flips priority so it wins the next conflict.
  always_comb begin
    conflict = !e_empty && !m_empty && (e_head.dst == m_head.dst);
    issue_e  = !e_empty && !(conflict && (prio_q == PRIO_M));
    issue_m  = !m_empty && !(conflict && (prio_q == PRIO_E));
    prio_d   = prio_q;
    if (issue_m) begin
      prio_d = PRIO_E;
    end else if (!m_empty) begin
      prio_d = PRIO_M;
    end
  end

  // Next write-port contents and sticky error.
  always_comb begin
    vldE_d = issue_e;
    dstE_d = issue_e ? {1'b0, e_head.dst} : NOREG;
    valE_d = issue_e ? e_head.data : '0;
    vldM_d = issue_m;
    dstM_d = issue_m ? {1'b0, m_head.dst} : NOREG;
    valM_d = issue_m ? m_head.data : '0;
    bad_d  = bad_q || (e_acc && !dst_in_range(e_dst))
                   || (m_acc && !dst_in_range(m_dst));
  end

  // Registered write ports, priority flag and error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_q <= PRIO_E;
      vldE_q <= 1'b0;
      dstE_q <= NOREG;
      valE_q <= '0;
      vldM_q <= 1'b0;
      dstM_q <= NOREG;
      valM_q <= '0;
      bad_q  <= 1'b0;
    end else begin
      prio_q <= prio_d;
      vldE_q <= vldE_d;
      dstE_q <= dstE_d;
      valE_q <= valE_d;
      vldM_q <= vldM_d;
      dstM_q <= dstM_d;
      valM_q <= valM_d;
      bad_q  <= bad_d;
    end
  end

  // Registers with a write still queued or on a port. Port validity is
  // tracked separately so a NOREG override inside r0..r7 cannot alias.
  always_comb begin
    pending = e_dst_vld | m_dst_vld;
    if (vldE_q) begin
      pending = pending | reg_onehot(dstE_q[REG_AW-1:0]);
    end
    if (vldM_q) begin
      pending = pending | reg_onehot(dstM_q[REG_AW-1:0]);
    end
  end

  assign idle    = e_empty && m_empty && !vldE_q && !vldM_q;
  assign dstE    = dstE_q;
  assign valE    = valE_q;
  assign dstM    = dstM_q;
  assign valM    = valM_q;
  assign bad_dst = bad_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: a per-cycle vector table covering
// issue latency, conflicts, anti-starvation, backpressure and bad destinations,
// followed by a hand-written reset-mid-stream sequence.
module tb_regfile_wb_sched;

  localparam logic [3:0] NR = 4'hF;

  logic        clock;
  logic        reset;
  logic        e_valid, m_valid;
  logic        e_ready, m_ready;
  logic [3:0]  e_dst, m_dst;
  logic [31:0] e_data, m_data;
  logic [3:0]  dstE, dstM;
  logic [31:0] valE, valM;
  logic [7:0]  pending;
  logic        idle, bad_dst;

  int total;
  int nbad;

  regfile_wb_sched #(.DEPTH(2), .NOREG(4'hF)) dut (
    .clock   (clock),
    .reset   (reset),
    .e_valid (e_valid),
    .e_ready (e_ready),
    .e_dst   (e_dst),
    .e_data  (e_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_dst   (m_dst),
    .m_data  (m_data),
    .dstE    (dstE),
    .valE    (valE),
    .dstM    (dstM),
    .valM    (valM),
    .pending (pending),
    .idle    (idle),
    .bad_dst (bad_dst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs held across one posedge, expected outputs just after that edge.
  typedef struct {
    logic        ev;
    logic [3:0]  ed;
    logic [31:0] edat;
    logic        mv;
    logic [3:0]  md;
    logic [31:0] mdat;
    logic        er;
    logic        mr;
    logic [3:0]  de;
    logic [31:0] ve;
    logic [3:0]  dm;
    logic [31:0] vm;
    logic [7:0]  pd;
    logic        idl;
    logic        bd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic ev, input logic [3:0] ed, input logic [31:0] edat,
    input logic mv, input logic [3:0] md, input logic [31:0] mdat,
    input logic er, input logic mr,
    input logic [3:0] de, input logic [31:0] ve,
    input logic [3:0] dm, input logic [31:0] vm,
    input logic [7:0] pd, input logic idl, input logic bd);
    vec_t v;
    v.ev = ev; v.ed = ed; v.edat = edat;
    v.mv = mv; v.md = md; v.mdat = mdat;
    v.er = er; v.mr = mr;
    v.de = de; v.ve = ve; v.dm = dm; v.vm = vm;
    v.pd = pd; v.idl = idl; v.bd = bd;
    return v;
  endfunction

  task automatic chk(input string name, input int step,
                     input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, step, got, want);
    end
  endtask

  task automatic drive(input logic ev, input logic [3:0] ed, input logic [31:0] edat,
                       input logic mv, input logic [3:0] md, input logic [31:0] mdat);
    e_valid = ev; e_dst = ed; e_data = edat;
    m_valid = mv; m_dst = md; m_data = mdat;
  endtask

  task automatic chk_reset_state(input int step);
    chk("rst_dstE",    step, 32'(dstE),    32'(NR));
    chk("rst_valE",    step, valE,         32'h0);
    chk("rst_dstM",    step, 32'(dstM),    32'(NR));
    chk("rst_valM",    step, valM,         32'h0);
    chk("rst_pending", step, 32'(pending), 32'h0);
    chk("rst_idle",    step, 32'(idle),    32'h1);
    chk("rst_bad",     step, 32'(bad_dst), 32'h0);
    chk("rst_e_ready", step, 32'(e_ready), 32'h1);
    chk("rst_m_ready", step, 32'(m_ready), 32'h1);
  endtask

  initial begin
    total = 0;
    nbad  = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // E-only write, one-cycle latency
    tbl.push_back(mk(1,4'd3,32'hABCDEF98, 0,0,0,          1,1, NR,0,            NR,0,            8'h08,0,0));
    tbl.push_back(mk(0,0,0,               0,0,0,          1,1, 4'd3,32'hABCDEF98, NR,0,          8'h08,0,0));
    tbl.push_back(mk(0,0,0,               0,0,0,          1,1, NR,0,            NR,0,            8'h00,1,0));
    // Same-register conflict: E first, M next cycle
    tbl.push_back(mk(1,4'd5,32'h11111111, 1,4'd5,32'h22222222, 1,1, NR,0,        NR,0,            8'h20,0,0));
    tbl.push_back(mk(0,0,0,               0,0,0,          1,1, 4'd5,32'h11111111, NR,0,          8'h20,0,0));
    tbl.push_back(mk(0,0,0,               0,0,0,          1,1, NR,0,            4'd5,32'h22222222, 8'h20,0,0));
    tbl.push_back(mk(0,0,0,               0,0,0,          1,1, NR,0,            NR,0,            8'h00,1,0));
    // Different registers issue together
    tbl.push_back(mk(1,4'd0,32'h0A0A0A0A, 1,4'd7,32'h07070707, 1,1, NR,0,        NR,0,            8'h81,0,0));
    tbl.push_back(mk(0,0,0,               0,0,0,          1,1, 4'd0,32'h0A0A0A0A, 4'd7,32'h07070707, 8'h81,0,0));
    tbl.push_back(mk(0,0,0,               0,0,0,          1,1, NR,0,            NR,0,            8'h00,1,0));
    // Anti-starvation: E streams r2, M writes r2 twice
    tbl.push_back(mk(1,4'd2,32'hE0000001, 1,4'd2,32'hA0000001, 1,1, NR,0,        NR,0,            8'h04,0,0));
    tbl.push_back(mk(1,4'd2,32'hE0000002, 1,4'd2,32'hA0000002, 1,0, 4'd2,32'hE0000001, NR,0,     8'h04,0,0));
    tbl.push_back(mk(1,4'd2,32'hE0000003, 0,0,0,          0,1, NR,0,            4'd2,32'hA0000001, 8'h04,0,0));
    tbl.push_back(mk(1,4'd2,32'hE0000004, 0,0,0,          1,1, 4'd2,32'hE0000002, NR,0,          8'h04,0,0));
    tbl.push_back(mk(1,4'd2,32'hE0000004, 0,0,0,          0,1, NR,0,            4'd2,32'hA0000002, 8'h04,0,0));
    tbl.push_back(mk(0,0,0,               0,0,0,          1,1, 4'd2,32'hE0000003, NR,0,          8'h04,0,0));
    tbl.push_back(mk(0,0,0,               0,0,0,          1,1, 4'd2,32'hE0000004, NR,0,          8'h04,0,0));
    tbl.push_back(mk(0,0,0,               0,0,0,          1,1, NR,0,            NR,0,            8'h00,1,0));
    // Backpressure: M held in conflict, third M waits for a pop
    tbl.push_back(mk(1,4'd1,32'h000000AA, 1,4'd1,32'h00000BB1, 1,1, NR,0,        NR,0,            8'h02,0,0));
    tbl.push_back(mk(0,0,0,               1,4'd6,32'h00000BB2, 1,0, 4'd1,32'h000000AA, NR,0,     8'h42,0,0));
    tbl.push_back(mk(0,0,0,               1,4'd7,32'h00000BB3, 1,1, NR,0,        4'd1,32'h00000BB1, 8'h42,0,0));
    tbl.push_back(mk(0,0,0,               1,4'd7,32'h00000BB3, 1,1, NR,0,        4'd6,32'h00000BB2, 8'hC0,0,0));
    tbl.push_back(mk(0,0,0,               0,0,0,          1,1, NR,0,            4'd7,32'h00000BB3, 8'h80,0,0));
    tbl.push_back(mk(0,0,0,               0,0,0,          1,1, NR,0,            NR,0,            8'h00,1,0));
    // Bad destinations are dropped, flag is sticky
    tbl.push_back(mk(1,4'h9,32'hDEADBEEF, 0,0,0,          1,1, NR,0,            NR,0,            8'h00,1,1));
    tbl.push_back(mk(0,0,0,               1,4'hA,32'h12345678, 1,1, NR,0,        NR,0,            8'h00,1,1));
    tbl.push_back(mk(1,4'd4,32'h00004444, 0,0,0,          1,1, NR,0,            NR,0,            8'h10,0,1));
    tbl.push_back(mk(0,0,0,               0,0,0,          1,1, 4'd4,32'h00004444, NR,0,          8'h10,0,1));
    tbl.push_back(mk(0,0,0,               0,0,0,          1,1, NR,0,            NR,0,            8'h00,1,1));

    repeat (2) @(posedge clock);
    #1;
    chk_reset_state(0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].ev, tbl[i].ed, tbl[i].edat, tbl[i].mv, tbl[i].md, tbl[i].mdat);
      @(posedge clock);
      #1;
      chk("e_ready", i + 1, 32'(e_ready), 32'(tbl[i].er));
      chk("m_ready", i + 1, 32'(m_ready), 32'(tbl[i].mr));
      chk("dstE",    i + 1, 32'(dstE),    32'(tbl[i].de));
      chk("valE",    i + 1, valE,         tbl[i].ve);
      chk("dstM",    i + 1, 32'(dstM),    32'(tbl[i].dm));
      chk("valM",    i + 1, valM,         tbl[i].vm);
      chk("pending", i + 1, 32'(pending), 32'(tbl[i].pd));
      chk("idle",    i + 1, 32'(idle),    32'(tbl[i].idl));
      chk("bad_dst", i + 1, 32'(bad_dst), 32'(tbl[i].bd));
    end

    // Reset mid-stream: build up queued and presented writes, then reset
    // asynchronously between edges.
    drive(1, 4'd3, 32'hC0DE0001, 1, 4'd3, 32'hC0DE0002);
    @(posedge clock);
    #1;
    drive(1, 4'd3, 32'hC0DE0003, 1, 4'd3, 32'hC0DE0004);
    @(posedge clock);
    #1;
    chk("pre_rst_dstE",    100, 32'(dstE),    32'h3);
    chk("pre_rst_valE",    100, valE,         32'hC0DE0001);
    chk("pre_rst_m_ready", 100, 32'(m_ready), 32'h0);
    chk("pre_rst_pending", 100, 32'(pending), 32'h08);
    chk("pre_rst_idle",    100, 32'(idle),    32'h0);
    drive(0, 0, 0, 0, 0, 0);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_state(101);
    @(posedge clock);
    #1;
    chk_reset_state(102);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk_reset_state(103);
    @(posedge clock);
    #1;
    chk("post_rst_dstE", 104, 32'(dstE), 32'(NR));
    chk("post_rst_dstM", 104, 32'(dstM), 32'(NR));
    chk("post_rst_idle", 104, 32'(idle), 32'h1);

    // Scheduler still works after reset.
    drive(0, 0, 0, 1, 4'd1, 32'h5A5A5A5A);
    @(posedge clock);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    chk("post_rst_q_pending", 105, 32'(pending), 32'h02);
    @(posedge clock);
    #1;
    chk("post_rst_dstM_issue", 106, 32'(dstM), 32'h1);
    chk("post_rst_valM_issue", 106, valM,      32'h5A5A5A5A);
    chk("post_rst_dstE_idle",  106, 32'(dstE), 32'(NR));

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
